// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer_if
// Purpose  : Event strobes in and tone control out between game logic and
//            the sound-effect sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface sfx_sequencer_if;
    logic        EVT_WALL;
    logic        EVT_PADDLE;
    logic        EVT_BRICK;
    logic        EVT_MISS;
    logic        MUTE;
    logic [15:0] HALF_PERIOD;
    logic        ENABLE;
    logic        BUSY;

    // master: game logic raising events; slave: the sequencer
    modport master (
        output EVT_WALL, EVT_PADDLE, EVT_BRICK, EVT_MISS, MUTE,
        input  HALF_PERIOD, ENABLE, BUSY
    );

    modport slave (
        input  EVT_WALL, EVT_PADDLE, EVT_BRICK, EVT_MISS, MUTE,
        output HALF_PERIOD, ENABLE, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer
// Purpose  : Turns game-event strobes into prioritised, timed tone sequences
//            for the square-wave synth.
// Revision : 1.0  initial release
// ============================================================================
module sfx_sequencer #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic           CLK,
    input  logic           RESET,
    sfx_sequencer_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [15:0] c_tick_last = 16'(TICK_CYCLES - 1);

    // Effect codes double as priority: WALL=0 .. MISS=3
    function automatic logic [15:0] f_half(input logic [1:0] eff, input logic [1:0] idx);
        logic [15:0] v;
        v = 16'd0;
        case ({eff, idx})
            4'b00_00: v = 16'd25000;
            4'b01_00: v = 16'd18000;
            4'b10_00: v = 16'd12000;
            4'b10_01: v = 16'd9000;
            4'b11_00: v = 16'd20000;
            4'b11_01: v = 16'd25000;
            4'b11_10: v = 16'd30000;
            4'b11_11: v = 16'd40000;
            default:  v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] f_dur(input logic [1:0] eff);
        logic [7:0] v;
        case (eff)
            2'd0:    v = 8'd20;
            2'd1:    v = 8'd40;
            2'd2:    v = 8'd30;
            default: v = 8'd100;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] f_last(input logic [1:0] eff);
        logic [1:0] v;
        case (eff)
            2'd2:    v = 2'd1;
            2'd3:    v = 2'd3;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    state_t      r_state;
    logic [3:0]  r_evt_prev;
    logic [1:0]  r_effect;
    logic [1:0]  r_note_idx;
    logic [15:0] r_presc;
    logic [7:0]  r_note_cnt;
    logic [15:0] r_half;
    logic        r_enable;
    logic        r_busy;

    logic [3:0]  w_evt;
    logic [3:0]  w_rise;
    logic [1:0]  w_new_pri;
    logic        w_accept;
    logic        w_wrap;
    logic        w_note_end;

    assign w_evt  = {bus.EVT_MISS, bus.EVT_BRICK, bus.EVT_PADDLE, bus.EVT_WALL};
    assign w_rise = w_evt & ~r_evt_prev;

    always_comb begin
        w_new_pri = 2'd0;
        if (w_rise[3])      w_new_pri = 2'd3;
        else if (w_rise[2]) w_new_pri = 2'd2;
        else if (w_rise[1]) w_new_pri = 2'd1;
    end

    assign w_accept   = (|w_rise) && ((r_state == S_IDLE) || (w_new_pri >= r_effect));
    assign w_wrap     = (r_presc == c_tick_last);
    // Counter reads duration-1 during the final tick of the note
    assign w_note_end = w_wrap && (r_note_cnt == (f_dur(r_effect) - 8'd1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_evt_prev <= 4'd0;
            r_effect   <= 2'd0;
            r_note_idx <= 2'd0;
            r_presc    <= 16'd0;
            r_note_cnt <= 8'd0;
            r_half     <= 16'd0;
            r_enable   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_evt_prev <= w_evt;
            if (w_accept) begin
                r_state    <= S_PLAY;
                r_effect   <= w_new_pri;
                r_note_idx <= 2'd0;
                r_presc    <= 16'd0;
                r_note_cnt <= 8'd0;
                r_half     <= f_half(w_new_pri, 2'd0);
                r_enable   <= ~bus.MUTE;
                r_busy     <= 1'b1;
            end else if (r_state == S_PLAY) begin
                r_enable <= ~bus.MUTE;
                if (w_wrap) begin
                    r_presc <= 16'd0;
                    if (w_note_end) begin
                        r_note_cnt <= 8'd0;
                        if (r_note_idx == f_last(r_effect)) begin
                            r_state  <= S_IDLE;
                            r_half   <= 16'd0;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_note_idx <= r_note_idx + 2'd1;
                            r_half     <= f_half(r_effect, r_note_idx + 2'd1);
                        end
                    end else begin
                        r_note_cnt <= r_note_cnt + 8'd1;
                    end
                end else begin
                    r_presc <= r_presc + 16'd1;
                end
            end
        end
    end

    assign bus.HALF_PERIOD = r_half;
    assign bus.ENABLE      = r_enable;
    assign bus.BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_sequencer
// Purpose  : Directed self-checking bench for sfx_sequencer (TICK_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_sfx_sequencer;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    sfx_sequencer_if bus ();

    sfx_sequencer #(.TICK_CYCLES(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Check outputs against expectation for n cycles, advancing each cycle
    task automatic hold(input string tag, input int n, input logic [15:0] hp,
                        input logic en, input logic bz);
        for (int i = 0; i < n; i++) begin
            total++;
            assert ({bus.HALF_PERIOD, bus.ENABLE, bus.BUSY} === {hp, en, bz}) else begin
                bad++;
                $error("FAIL %s[%0d]: got hp=%0d en=%b busy=%b, expected hp=%0d en=%b busy=%b",
                       tag, i, bus.HALF_PERIOD, bus.ENABLE, bus.BUSY, hp, en, bz);
            end
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b1;
        bus.EVT_WALL   = 1'b0;
        bus.EVT_PADDLE = 1'b0;
        bus.EVT_BRICK  = 1'b0;
        bus.EVT_MISS   = 1'b0;
        bus.MUTE       = 1'b0;
        step(); step(); step();
        RESET = 1'b0;
        hold("idle", 100, 16'd0, 1'b0, 1'b0);

        // Single-note WALL: 20 ticks x 4 = 80 cycles
        bus.EVT_WALL = 1'b1; step(); bus.EVT_WALL = 1'b0;
        hold("wall", 80, 16'd25000, 1'b1, 1'b1);
        hold("wall_end", 1, 16'd0, 1'b0, 1'b0);
        hold("gap1", 5, 16'd0, 1'b0, 1'b0);

        // MISS held high for 2000 cycles plays exactly once
        bus.EVT_MISS = 1'b1; step();
        hold("miss0", 400, 16'd20000, 1'b1, 1'b1);
        hold("miss1", 400, 16'd25000, 1'b1, 1'b1);
        hold("miss2", 400, 16'd30000, 1'b1, 1'b1);
        hold("miss3", 400, 16'd40000, 1'b1, 1'b1);
        hold("miss_lvl", 399, 16'd0, 1'b0, 1'b0);
        bus.EVT_MISS = 1'b0;
        hold("miss_fall", 5, 16'd0, 1'b0, 1'b0);

        // BRICK ignores a later PADDLE; 240 cycles total
        bus.EVT_BRICK = 1'b1; step(); bus.EVT_BRICK = 1'b0;
        hold("brick_a", 20, 16'd12000, 1'b1, 1'b1);
        bus.EVT_PADDLE = 1'b1;
        hold("brick_p", 1, 16'd12000, 1'b1, 1'b1);
        bus.EVT_PADDLE = 1'b0;
        hold("brick_b", 99, 16'd12000, 1'b1, 1'b1);
        hold("brick_n1", 120, 16'd9000, 1'b1, 1'b1);
        hold("brick_end", 1, 16'd0, 1'b0, 1'b0);
        hold("gap2", 3, 16'd0, 1'b0, 1'b0);

        // WALL and BRICK together: BRICK wins
        bus.EVT_WALL = 1'b1; bus.EVT_BRICK = 1'b1; step();
        bus.EVT_WALL = 1'b0; bus.EVT_BRICK = 1'b0;
        hold("both_n0", 120, 16'd12000, 1'b1, 1'b1);
        hold("both_n1", 120, 16'd9000, 1'b1, 1'b1);
        hold("both_end", 1, 16'd0, 1'b0, 1'b0);

        // PADDLE retrigger after 100 cycles: 160 more from the second accept
        bus.EVT_PADDLE = 1'b1; step(); bus.EVT_PADDLE = 1'b0;
        hold("pad_a", 99, 16'd18000, 1'b1, 1'b1);
        bus.EVT_PADDLE = 1'b1;
        hold("pad_r", 1, 16'd18000, 1'b1, 1'b1);
        bus.EVT_PADDLE = 1'b0;
        hold("pad_b", 160, 16'd18000, 1'b1, 1'b1);
        hold("pad_end", 1, 16'd0, 1'b0, 1'b0);

        // MISS preempts BRICK, then MUTE gating, then reset mid-play
        bus.EVT_BRICK = 1'b1; step(); bus.EVT_BRICK = 1'b0;
        hold("pre_brick", 50, 16'd12000, 1'b1, 1'b1);
        bus.EVT_MISS = 1'b1; step(); bus.EVT_MISS = 1'b0;
        hold("preempt", 10, 16'd20000, 1'b1, 1'b1);
        bus.MUTE = 1'b1;
        hold("mute_lag", 1, 16'd20000, 1'b1, 1'b1);
        hold("mute_n0", 389, 16'd20000, 1'b0, 1'b1);
        hold("mute_n1", 400, 16'd25000, 1'b0, 1'b1);
        bus.MUTE = 1'b0;
        hold("unmute_lag", 1, 16'd30000, 1'b0, 1'b1);
        hold("unmute_n2", 399, 16'd30000, 1'b1, 1'b1);
        hold("unmute_n3", 100, 16'd40000, 1'b1, 1'b1);
        RESET = 1'b1; step();
        hold("rst_mid", 1, 16'd0, 1'b0, 1'b0);
        RESET = 1'b0;
        hold("rst_after", 5, 16'd0, 1'b0, 1'b0);

        // Input already high when reset releases counts as an edge
        RESET = 1'b1; bus.EVT_WALL = 1'b1; step(); step();
        RESET = 1'b0; step(); bus.EVT_WALL = 1'b0;
        hold("rst_edge", 80, 16'd25000, 1'b1, 1'b1);
        hold("rst_edge_end", 1, 16'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfx_sequencer.md
# sfx_sequencer

Game sound-effect sequencer driving the square-wave tone generator. Turns single game-event strobes (wall bounce, paddle hit, brick hit, ball lost) into timed sequences of tones from a fixed internal note table. It presents a half-period word and an enable to the downstream synth, and arbitrates overlapping events by priority.

## Interface
- TICK_CYCLES, 50000: CLK cycles per duration tick (1 ms at 50 MHz); legal range 1..65535.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- EVT_WALL  in  1  ball hit wall; priority 0 (lowest).
- EVT_PADDLE  in  1  ball hit paddle; priority 1.
- EVT_BRICK  in  1  ball hit brick; priority 2.
- EVT_MISS  in  1  ball lost; priority 3 (highest).
- MUTE  in  1  forces ENABLE low; sequencing continues unaffected.
- HALF_PERIOD  out  16  half period in CLK cycles for the synth; registered.
- ENABLE  out  1  synth enable; registered.
- BUSY  out  1  high while an effect is playing (independent of MUTE).

## Operation
- Event inputs are rising-edge detected: one registered previous-value bit per input, cleared by RESET. Level held high triggers once; an input already high when RESET deasserts counts as an edge.
- Note table (half period / duration in ticks), fixed in ROM:
  - WALL: 25000/20.
  - PADDLE: 18000/40.
  - BRICK: 12000/30, 9000/30.
  - MISS: 20000/100, 25000/100, 30000/100, 40000/100.
- States: IDLE, PLAY. Registers: current effect (2 bits), note index (2 bits), tick prescaler (16 bits), tick-in-note counter (8 bits).
- Accept rule: among edges detected in one cycle, take the highest priority. Accept if IDLE, or PLAY and new priority >= current priority. Lower-priority edges during PLAY are dropped, never queued.
- Accept: load effect, note index 0, clear prescaler and note counter, enter PLAY, drive note 0.
- PLAY: prescaler counts 0..TICK_CYCLES-1, wraps and increments note counter. When note counter reaches the note's duration on a wrap:
  - more notes remain: advance index, clear note counter, drive next note;
  - last note: go IDLE.
- An accept in the same cycle as a note end wins; the note end is discarded.
- IDLE outputs: HALF_PERIOD=0, ENABLE=0, BUSY=0.
- PLAY outputs: HALF_PERIOD=current note, BUSY=1, ENABLE=~MUTE. There is no gap between consecutive notes.

## Timing
- Reset values: HALF_PERIOD=0, ENABLE=0, BUSY=0, state IDLE, edge registers 0. RESET mid-effect aborts on the next edge.
- Event rises in cycle c → outputs for note 0 valid in cycle c+1.
- Each note is held for exactly duration×TICK_CYCLES cycles. For a single-note effect accepted with outputs starting at cycle s, the idle outputs appear at cycle s+duration×TICK_CYCLES.
- Retrigger (equal or higher priority) restarts timing from the accept cycle; the partial note is not completed.
- MUTE is combinationally gated into the ENABLE register: a MUTE change in cycle c affects ENABLE in cycle c+1.

## Test plan
- Reset/idle: TICK_CYCLES=4. Hold RESET 3 cycles, then release with all inputs low → HALF_PERIOD=0, ENABLE=0, BUSY=0 for 100 cycles.
- Single effect: EVT_WALL pulse at cycle 10 → cycles 11..90 show HALF_PERIOD=25000, ENABLE=1, BUSY=1; cycle 91 shows all zero.
- Multi-note: EVT_MISS pulse → four 400-cycle segments at 20000, 25000, 30000, 40000 with ENABLE continuously high; then idle. Holding EVT_MISS high for 2000 cycles gives only one playback.
- Priority: EVT_BRICK, then EVT_PADDLE 20 cycles later → PADDLE ignored, BRICK completes in 240 cycles. EVT_MISS during BRICK → HALF_PERIOD=20000 the next cycle. EVT_WALL+EVT_BRICK in the same cycle → BRICK plays.
- Retrigger: EVT_PADDLE, then EVT_PADDLE again 100 cycles later → 18000 held 160 cycles from the second accept (260 total).
- MUTE/reset mid-play: MUTE high during MISS → ENABLE=0, HALF_PERIOD and BUSY unchanged, timing unchanged. RESET mid-play → all outputs 0 next cycle.
